// File: rtl/sc_levelup_generator.sv
// sc_levelup_generator
//
// Purpose:
//   Produces the one-clock, active-low level-up pulse for the level counter.
//   It emits the pulse once each time the frog crosses from the start row to
//   the goal row while the game is running. After a crossing, a celebration
//   hold runs. The frog must then return to the start row before the
//   generator re-arms, so one crossing can never be counted twice.
//
// Ports:
//   SC_LEVELUPGEN_CLOCK_50            system clock, rising edge active
//   SC_LEVELUPGEN_RESET_InLow         asynchronous active-low reset
//   SC_LEVELUPGEN_CurrentState_InBus  game state (0=AWAITSTART, 1=STARTGAME, 2=ENDGAME)
//   SC_LEVELUPGEN_FrogRow_InBus       current frog row
//   SC_LEVELUPGEN_Level_InBus         current level, fed back from the level counter
//   SC_LEVELUPGEN_CountSignal_OutLow  level-up pulse, low for exactly one clock
//   SC_LEVELUPGEN_LevelDone_OutHigh   high while the pulse or celebration hold runs
//   SC_LEVELUPGEN_Armed_OutHigh       high while waiting for the frog to reach the goal
//
// Every output is a flop. Each one is loaded from a decode of the next state,
// so its value always equals a decode of the current state register. No input
// reaches an output without passing through a flop.

module sc_levelup_generator #(
  parameter int unsigned CURRENTSTATE_DATAWIDTH = 2,
  parameter int unsigned ROW_DATAWIDTH          = 4,
  parameter int unsigned LEVEL_DATAWIDTH        = 3,
  parameter int unsigned START_ROW              = 15,
  parameter int unsigned GOAL_ROW               = 0,
  parameter int unsigned MAX_LEVEL              = 3,
  parameter int unsigned HOLD_DATAWIDTH         = 4,
  parameter int unsigned HOLD_CYCLES            = 8
) (
  input  logic                              SC_LEVELUPGEN_CLOCK_50,
  input  logic                              SC_LEVELUPGEN_RESET_InLow,
  input  logic [CURRENTSTATE_DATAWIDTH-1:0] SC_LEVELUPGEN_CurrentState_InBus,
  input  logic [ROW_DATAWIDTH-1:0]          SC_LEVELUPGEN_FrogRow_InBus,
  input  logic [LEVEL_DATAWIDTH-1:0]        SC_LEVELUPGEN_Level_InBus,
  output logic                              SC_LEVELUPGEN_CountSignal_OutLow,
  output logic                              SC_LEVELUPGEN_LevelDone_OutHigh,
  output logic                              SC_LEVELUPGEN_Armed_OutHigh
);

  localparam logic [CURRENTSTATE_DATAWIDTH-1:0] GameStart =
      CURRENTSTATE_DATAWIDTH'(1);
  localparam logic [ROW_DATAWIDTH-1:0]   StartRow = ROW_DATAWIDTH'(START_ROW);
  localparam logic [ROW_DATAWIDTH-1:0]   GoalRow  = ROW_DATAWIDTH'(GOAL_ROW);
  localparam logic [LEVEL_DATAWIDTH-1:0] MaxLevel = LEVEL_DATAWIDTH'(MAX_LEVEL);
  // The hold counter counts from HOLD_CYCLES-1 down to 0. That gives
  // HOLD_CYCLES clocks in the hold state.
  localparam logic [HOLD_DATAWIDTH-1:0]  HoldLoad = HOLD_DATAWIDTH'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StArmed      = 3'd1,
    StPulse      = 3'd2,
    StHold       = 3'd3,
    StWaitReturn = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [HOLD_DATAWIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                      count_n_q, count_n_d;
  logic                      done_q, done_d;
  logic                      armed_q, armed_d;

  // Input qualifiers
  logic game_running;
  logic at_start;
  logic at_goal;
  logic below_max;

  // Encoding 3 is unknown and must not count as "running". An exact match
  // against STARTGAME handles that case.
  assign game_running = (SC_LEVELUPGEN_CurrentState_InBus == GameStart);
  assign at_start     = (SC_LEVELUPGEN_FrogRow_InBus == StartRow);
  assign at_goal      = (SC_LEVELUPGEN_FrogRow_InBus == GoalRow);
  assign below_max    = (SC_LEVELUPGEN_Level_InBus < MaxLevel);

  // State and output registers
  always_ff @(posedge SC_LEVELUPGEN_CLOCK_50 or negedge SC_LEVELUPGEN_RESET_InLow) begin
    if (!SC_LEVELUPGEN_RESET_InLow) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      count_n_q  <= 1'b1;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      count_n_q  <= count_n_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;

    if ((state_q != StIdle) && !game_running) begin
      // Leaving the running game overrides every other transition. This
      // discards any pending hold and never emits a pulse.
      state_d    = StIdle;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          hold_cnt_d = '0;
          if (game_running && at_start) begin
            state_d = StArmed;
          end
        end

        StArmed: begin
          // The level is only looked at here, at the moment the goal is
          // reached. At or above the maximum, the celebration still runs but
          // no pulse is emitted.
          if (at_goal) begin
            if (below_max) begin
              state_d = StPulse;
            end else begin
              state_d    = StHold;
              hold_cnt_d = HoldLoad;
            end
          end
        end

        StPulse: begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
        end

        StHold: begin
          if (hold_cnt_q == '0) begin
            state_d = StWaitReturn;
          end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end

        StWaitReturn: begin
          // Only the start row re-arms. A frog that stays on, or returns to,
          // the goal row is ignored.
          if (at_start) begin
            state_d = StArmed;
          end
        end

        default: begin
          state_d    = StIdle;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Output decode. Applied to the next state so that the output flops track
  // the state register exactly.
  always_comb begin
    count_n_d = 1'b1;
    done_d    = 1'b0;
    armed_d   = 1'b0;
    case (state_d)
      StArmed: armed_d   = 1'b1;
      StPulse: begin
        count_n_d = 1'b0;
        done_d    = 1'b1;
      end
      StHold:  done_d    = 1'b1;
      default: begin
        count_n_d = 1'b1;
        done_d    = 1'b0;
        armed_d   = 1'b0;
      end
    endcase
  end

  assign SC_LEVELUPGEN_CountSignal_OutLow = count_n_q;
  assign SC_LEVELUPGEN_LevelDone_OutHigh  = done_q;
  assign SC_LEVELUPGEN_Armed_OutHigh      = armed_q;

endmodule

// File: tb/tb_sc_levelup_generator.sv
// Testbench for sc_levelup_generator.
// It applies a table of per-cycle vectors, followed by hand-written sequences:
// an asynchronous reset during the hold, a frog that sits on the goal row, and
// repeated crossings with a level counter model fed back into the design.

module tb_sc_levelup_generator;

  // Expected outputs packed as {CountSignal_OutLow, LevelDone_OutHigh, Armed_OutHigh}
  localparam logic [2:0] IDL = 3'b100;
  localparam logic [2:0] ARM = 3'b101;
  localparam logic [2:0] PUL = 3'b010;
  localparam logic [2:0] HLD = 3'b110;
  localparam logic [2:0] WAI = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cs;
  logic [3:0] row;
  logic [2:0] lvl_drv;
  logic [2:0] lvl_cnt;
  logic [2:0] lvl;
  logic       loop_en;
  logic       cnt_n;
  logic       done;
  logic       armed;

  always #5 clk = ~clk;

  // Level counter model: it increments on the edge that samples the pulse low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_cnt <= 3'd0;
    else if (!cnt_n) lvl_cnt <= lvl_cnt + 3'd1;
  end

  assign lvl = loop_en ? lvl_cnt : lvl_drv;

  sc_levelup_generator dut (
    .SC_LEVELUPGEN_CLOCK_50           (clk),
    .SC_LEVELUPGEN_RESET_InLow        (rst_n),
    .SC_LEVELUPGEN_CurrentState_InBus (cs),
    .SC_LEVELUPGEN_FrogRow_InBus      (row),
    .SC_LEVELUPGEN_Level_InBus        (lvl),
    .SC_LEVELUPGEN_CountSignal_OutLow (cnt_n),
    .SC_LEVELUPGEN_LevelDone_OutHigh  (done),
    .SC_LEVELUPGEN_Armed_OutHigh      (armed)
  );

  typedef struct {
    logic [1:0] cs;
    logic [3:0] row;
    logic [2:0] lvl;
    logic [2:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, and compare
  // them just after the edge.
  task automatic step(input logic [1:0] c, input logic [3:0] r, input logic [2:0] l,
                      input logic [2:0] e, input string name);
    sb_t got;
    cs      = c;
    row     = r;
    lvl_drv = l;
    sb_q.push_back('{exp: e, name: name});
    @(posedge clk);
    #1;
    if (!cnt_n) pulses++;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb_q.pop_front();
      check(got.name, {29'd0, cnt_n, done, armed}, {29'd0, got.exp});
    end
  endtask

  task automatic add(input logic [1:0] c, input logic [3:0] r, input logic [2:0] l,
                     input logic [2:0] e);
    vecs.push_back('{cs: c, row: r, lvl: l, exp: e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    cs      = 2'd0;
    row     = 4'd0;
    lvl_drv = 3'd0;
    loop_en = 1'b0;
    #12;
    check("reset_state", {29'd0, cnt_n, done, armed}, {29'd0, IDL});
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    add(2'd0, 4'd15, 3'd0, IDL);                       // not running: stay idle
    add(2'd1, 4'd15, 3'd0, ARM);
    add(2'd1, 4'd8,  3'd0, ARM);
    add(2'd1, 4'd0,  3'd0, PUL);                       // goal reached, level 0
    for (int i = 0; i < 8; i++) add(2'd1, 4'd0, 3'd0, HLD);
    add(2'd1, 4'd0,  3'd0, WAI);
    add(2'd1, 4'd7,  3'd0, WAI);
    add(2'd1, 4'd15, 3'd3, ARM);
    add(2'd1, 4'd0,  3'd3, HLD);                       // max level: hold, no pulse
    for (int i = 0; i < 7; i++) add(2'd1, 4'd0, 3'd3, HLD);
    add(2'd1, 4'd0,  3'd0, WAI);
    add(2'd1, 4'd15, 3'd0, ARM);
    add(2'd1, 4'd0,  3'd2, PUL);                       // level 2 still below max
    for (int i = 0; i < 3; i++) add(2'd1, 4'd0, 3'd0, HLD);
    add(2'd2, 4'd0,  3'd0, IDL);                       // end of game during hold cycle 3
    add(2'd1, 4'd0,  3'd0, IDL);                       // must see start row first
    add(2'd1, 4'd15, 3'd0, ARM);
    add(2'd3, 4'd15, 3'd0, IDL);                       // unknown encoding
    add(2'd1, 4'd15, 3'd0, ARM);
    add(2'd1, 4'd15, 3'd4, ARM);                       // level ignored off goal row
    add(2'd0, 4'd15, 3'd0, IDL);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cs, vecs[i].row, vecs[i].lvl, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of the hold
    step(2'd1, 4'd15, 3'd0, ARM, "t1_arm");
    step(2'd1, 4'd0,  3'd0, PUL, "t1_pulse");
    step(2'd1, 4'd0,  3'd0, HLD, "t1_hold1");
    step(2'd1, 4'd0,  3'd0, HLD, "t1_hold2");
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_reset", {29'd0, cnt_n, done, armed}, {29'd0, IDL});
    @(negedge clk);
    rst_n = 1'b1;
    step(2'd1, 4'd0,  3'd0, IDL, "t1_idle_after_reset");
    step(2'd1, 4'd15, 3'd0, ARM, "t1_rearm");

    // Frog sits on the goal row well past the hold
    pulses = 0;
    step(2'd1, 4'd0, 3'd0, PUL, "t3_pulse");
    for (int i = 0; i < 50; i++) begin
      step(2'd1, 4'd0, 3'd0, (i < 8) ? HLD : WAI, $sformatf("t3_sit%0d", i));
    end
    step(2'd1, 4'd7, 3'd0, WAI, "t3_row7");
    check("t3_pulse_count", pulses, 1);

    // Repeated crossings, with the level counter model closing the loop
    rst_n   = 1'b0;
    loop_en = 1'b1;
    cs      = 2'd0;
    #2;
    rst_n = 1'b1;
    check("t6_level_reset", {29'd0, lvl_cnt}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step(2'd1, 4'd15, 3'd0, ARM, $sformatf("t6_arm%0d", c));
      if (c < 3) step(2'd1, 4'd0, 3'd0, PUL, $sformatf("t6_pulse%0d", c));
      for (int h = 0; h < 8; h++) begin
        step(2'd1, 4'd0, 3'd0, HLD, $sformatf("t6_hold%0d_%0d", c, h));
      end
      step(2'd1, 4'd0, 3'd0, WAI, $sformatf("t6_wait%0d", c));
    end
    check("t6_pulse_count", pulses, 3);
    check("t6_final_level", {29'd0, lvl_cnt}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
